filter_output_gate: RTL and testbench

FILTER_OUTPUT_GATE -- requirements
Module: filter_output_gate

---
 rtl/filter_output_gate.sv | 141 ++++++++++++++
 tb/tb_filter_output_gate.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_output_gate.sv
// filter_output_gate
//   Buffers ingress packets in a FIFO while the header filter decides their
//   fate, then either forwards the buffered packet to egress or discards it.
//   After each packet a one-cycle hdr_clear pulse releases the filter, and the
//   gate waits for verdict_valid to fall so a stale verdict is never reused.
//
// Ports
//   axi_aclk, axi_aresetn       clock, asynchronous active-low reset
//   s_axis_t{data,keep,user,last,valid}, s_axis_tready   ingress stream
//   m_axis_t{data,keep,user,last,valid}, m_axis_tready   egress stream
//   verdict_send, verdict_valid filter decision (1 = forward, 0 = drop)
//   hdr_clear                   one-cycle release pulse to the filter
//   fwd_count, drop_count       wrapping packet counters
module filter_output_gate #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int FIFO_DEPTH         = 64
) (
  input  logic                              axi_aclk,
  input  logic                              axi_aresetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                              s_axis_tlast,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  input  logic                              verdict_send,
  input  logic                              verdict_valid,
  output logic                              hdr_clear,
  output logic [31:0]                       fwd_count,
  output logic [31:0]                       drop_count
);

  localparam int KW = C_AXIS_DATA_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = C_AXIS_DATA_WIDTH + KW + C_AXIS_TUSER_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, FORWARD, DROP, CLEAR, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     occ;
  logic            full, empty, push, pop;
  logic            rdy_q;
  logic            send_q;
  logic [EW-1:0]   head;
  logic            head_last;

  // Full is judged on occupancy before any same-cycle pop.
  assign full          = (occ == (AW+1)'(FIFO_DEPTH));
  assign empty         = (occ == '0);
  // rdy_q holds tready low during reset and raises it one edge after release.
  assign s_axis_tready = rdy_q & ~full;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign head          = mem[rd_ptr];
  assign head_last     = head[0];

  // Data outputs are zeroed whenever no word is offered, so reset clears them
  // in the same cycle; while tvalid is high they follow the unmoved FIFO head.
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} =
    m_axis_tvalid ? head : '0;

  always_comb begin
    state_nxt     = state;
    m_axis_tvalid = 1'b0;
    pop           = 1'b0;
    hdr_clear     = 1'b0;
    unique case (state)
      IDLE: begin
        if (verdict_valid && !empty)
          state_nxt = verdict_send ? FORWARD : DROP;
      end
      FORWARD: begin
        m_axis_tvalid = ~empty;
        pop           = m_axis_tvalid & m_axis_tready;
        if (pop && head_last) state_nxt = CLEAR;
      end
      DROP: begin
        pop = ~empty;
        if (pop && head_last) state_nxt = CLEAR;
      end
      CLEAR: begin
        hdr_clear = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!verdict_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= IDLE;
      send_q     <= 1'b0;
      fwd_count  <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE)
        send_q <= verdict_send;
      if (state == CLEAR) begin
        if (send_q) fwd_count  <= fwd_count + 32'd1;
        else        drop_count <= drop_count + 32'd1;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge axi_aclk) begin
    if (push)
      mem[wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
  end

endmodule

// File: tb/tb_filter_output_gate.sv
// Testbench for filter_output_gate: directed scenarios plus randomized packets
// checked against a queue-based packet model.
module tb_filter_output_gate;

  localparam int DW = 64;
  localparam int TW = 16;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [TW-1:0] u;
    logic          l;
  } word_t;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [TW-1:0] s_axis_tuser;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [TW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          verdict_send;
  logic          verdict_valid;
  logic          hdr_clear;
  logic [31:0]   fwd_count;
  logic [31:0]   drop_count;

  int            total = 0;
  int            bad   = 0;
  word_t         exp_q[$];
  int            pkt_acc = 0;
  int            rdy_mode = 0;
  logic [31:0]   exp_fwd = '0;
  logic [31:0]   exp_drop = '0;

  filter_output_gate #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(TW),
    .FIFO_DEPTH        (4)
  ) dut (
    .axi_aclk     (clk),
    .axi_aresetn  (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .verdict_send (verdict_send),
    .verdict_valid(verdict_valid),
    .hdr_clear    (hdr_clear),
    .fwd_count    (fwd_count),
    .drop_count   (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Egress consumer: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Egress monitor: order/content against the model queue, stability while
  // stalled, and single-cycle hdr_clear.
  initial begin
    word_t cur, held, e;
    bit    stall, prev_hc;
    stall = 0;
    prev_hc = 0;
    forever begin
      @(negedge clk);
      cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
      if (!rst_n) begin
        stall = 0;
        prev_hc = 0;
      end else begin
        if (prev_hc) chk("hdr_clear_width", 128'(hdr_clear), 128'(0));
        prev_hc = hdr_clear;
        if (stall) begin
          chk("stall_valid", 128'(m_axis_tvalid), 128'(1));
          chk("stall_data", 128'(cur), 128'(held));
        end
        if (m_axis_tvalid) begin
          if (m_axis_tready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_word", 128'(m_axis_tvalid), 128'(0));
            end else begin
              e = exp_q.pop_front();
              chk("egress_word", 128'(cur), 128'(e));
            end
            stall = 0;
          end else begin
            stall = 1;
            held = cur;
          end
        end else begin
          stall = 0;
        end
      end
    end
  end

  task automatic send_pkt(input int n, input bit fwd);
    word_t w;
    bit    ok;
    int    t;
    pkt_acc = 0;
    for (int i = 0; i < n; i++) begin
      w.d = {$urandom, $urandom};
      w.k = KW'($urandom);
      w.u = TW'($urandom);
      w.l = (i == n - 1);
      if (fwd) exp_q.push_back(w);
      s_axis_tdata  = w.d;
      s_axis_tkeep  = w.k;
      s_axis_tuser  = w.u;
      s_axis_tlast  = w.l;
      s_axis_tvalid = 1'b1;
      ok = 0;
      t = 0;
      while (!ok && t < 300) begin
        @(negedge clk);
        ok = s_axis_tready;
        step();
        t++;
      end
      if (!ok) chk("ingress_timeout", 128'(s_axis_tready), 128'(1));
      pkt_acc++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Filter model: raise the verdict once the packet has started arriving,
  // flip verdict_send after it has been latched, then wait for hdr_clear.
  task automatic give_verdict(input bit send, input int hold);
    int t;
    bit found;
    t = 0;
    while (pkt_acc < 1 && t < 300) begin
      step();
      t++;
    end
    verdict_valid = 1'b1;
    verdict_send  = send;
    step();
    verdict_send = ~send;
    found = 0;
    t = 0;
    while (!found && t < 300) begin
      @(negedge clk);
      if (hdr_clear) begin
        found = 1;
      end else begin
        if (!send) chk("drop_tvalid", 128'(m_axis_tvalid), 128'(0));
        step();
      end
      t++;
    end
    if (!found) chk("hdr_clear_timeout", 128'(hdr_clear), 128'(1));
    if (send) exp_fwd++;
    else      exp_drop++;
    repeat (hold) begin
      step();
      @(negedge clk);
      chk("hold_tvalid", 128'(m_axis_tvalid), 128'(0));
    end
    step();
    verdict_valid = 1'b0;
    verdict_send  = 1'b0;
    step();
    chk("fwd_count", 128'(fwd_count), 128'(exp_fwd));
    chk("drop_count", 128'(drop_count), 128'(exp_drop));
  endtask

  initial begin
    rst_n = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tuser = '0;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    verdict_send = 1'b0;
    verdict_valid = 1'b0;

    // Reset state and tready release timing
    repeat (3) step();
    chk("rst_tready", 128'(s_axis_tready), 128'(0));
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_hdr_clear", 128'(hdr_clear), 128'(0));
    chk("rst_fwd", 128'(fwd_count), 128'(0));
    chk("rst_drop", 128'(drop_count), 128'(0));
    rst_n = 1'b1;
    #1;
    chk("tready_before_edge", 128'(s_axis_tready), 128'(0));
    step();
    chk("tready_after_edge", 128'(s_axis_tready), 128'(1));

    // 3-word forward, then 3-word drop
    rdy_mode = 0;
    fork
      send_pkt(3, 1);
      give_verdict(1, 0);
    join
    chk("fwd3_drained", 128'(exp_q.size()), 128'(0));
    fork
      send_pkt(3, 0);
      give_verdict(0, 0);
    join

    // 6 words into a 4-deep buffer with no verdict yet
    fork
      send_pkt(6, 1);
      begin
        repeat (10) step();
        @(negedge clk);
        chk("full_tready", 128'(s_axis_tready), 128'(0));
        chk("full_accepted", 128'(pkt_acc), 128'(4));
        give_verdict(1, 0);
      end
    join
    chk("fwd6_drained", 128'(exp_q.size()), 128'(0));

    // Verdict held past hdr_clear with a second packet already buffered
    fork
      begin
        send_pkt(3, 1);
        send_pkt(3, 1);
      end
      give_verdict(1, 3);
    join
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_verdict", 128'(m_axis_tvalid), 128'(0));
      step();
    end
    give_verdict(1, 0);
    chk("second_drained", 128'(exp_q.size()), 128'(0));

    // Egress back-pressure toggling every cycle
    rdy_mode = 1;
    fork
      send_pkt(5, 1);
      give_verdict(1, 0);
    join
    chk("toggle_drained", 128'(exp_q.size()), 128'(0));

    // Randomized packets
    for (int p = 0; p < 10; p++) begin
      int len;
      bit snd;
      len = $urandom_range(1, 7);
      snd = 1'($urandom_range(0, 1));
      rdy_mode = $urandom_range(0, 2);
      fork
        send_pkt(len, snd);
        give_verdict(snd, $urandom_range(0, 2));
      join
      chk("rand_drained", 128'(exp_q.size()), 128'(0));
    end

    // Reset in the middle of forwarding
    rdy_mode = 1;
    verdict_valid = 1'b1;
    verdict_send  = 1'b1;
    send_pkt(5, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("midrst_tdata", 128'(m_axis_tdata), 128'(0));
    chk("midrst_tready", 128'(s_axis_tready), 128'(0));
    chk("midrst_hdr_clear", 128'(hdr_clear), 128'(0));
    chk("midrst_fwd", 128'(fwd_count), 128'(0));
    chk("midrst_drop", 128'(drop_count), 128'(0));
    exp_q.delete();
    verdict_valid = 1'b0;
    verdict_send  = 1'b0;
    exp_fwd  = '0;
    exp_drop = '0;
    rdy_mode = 0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_fwd", 128'(fwd_count), 128'(0));
    chk("post_rst_drop", 128'(drop_count), 128'(0));
    fork
      send_pkt(3, 1);
      give_verdict(1, 0);
    join
    chk("post_rst_drained", 128'(exp_q.size()), 128'(0));

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
